// File: rtl/fifo_sync_if.sv
// fifo_sync port bundle: write side, read side, status and error flags.
// master drives requests; slave is the FIFO itself.
interface fifo_sync_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 12
);
  logic [DATA_WIDTH-1:0]  din;
  logic                   wr;
  logic                   full;
  logic                   almost_full;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   rd;
  logic                   dout_valid;
  logic                   empty;
  logic                   almost_empty;
  logic [ADDRESS_WIDTH:0] cnt;
  logic                   err_clr;
  logic                   ovf;
  logic                   udf;

  modport master (
    output din, wr, rd, err_clr,
    input  full, almost_full, dout, dout_valid,
    input  empty, almost_empty, cnt, ovf, udf
  );

  modport slave (
    input  din, wr, rd, err_clr,
    output full, almost_full, dout, dout_valid,
    output empty, almost_empty, cnt, ovf, udf
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with exact count, thresholds and sticky errors.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads.
module fifo_sync #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 12,
  parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
  parameter int AFULL_LVL     = FIFO_DEPTH - 4,
  parameter int AEMPTY_LVL    = 4
) (
  input logic        clk,
  input logic        rst,
  fifo_sync_if.slave bus
);
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic                     afull_q, afull_d;
  logic                     aempty_q, aempty_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     dval_q, dval_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     wr_acc;
  logic                     rd_acc;
`ifdef FIFO_SYNC_FWFT_EN
  logic [CW-1:0]            ram_cnt_q, ram_cnt_d;
  logic                     load;
`endif

  // Accept decisions, counters, flags and read-side next state.
  always_comb begin
    wr_acc   = bus.wr && !full_q;
    rd_acc   = bus.rd && !empty_q;
    wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(wr_acc);
    cnt_d    = cnt_q + CW'(wr_acc) - CW'(rd_acc);
    full_d   = (cnt_d == DEPTH_C);
    afull_d  = (cnt_d >= AFULL_C);
    aempty_d = (cnt_d <= AEMPTY_C);
    ovf_d    = (bus.wr && full_q) || (ovf_q && !bus.err_clr);
    udf_d    = (bus.rd && empty_q) || (udf_q && !bus.err_clr);
`ifdef FIFO_SYNC_FWFT_EN
    // Refill the output register whenever it is free or being popped.
    load      = (ram_cnt_q != '0) && (!dval_q || rd_acc);
    ram_cnt_d = ram_cnt_q + CW'(wr_acc) - CW'(load);
    rd_ptr_d  = rd_ptr_q + ADDRESS_WIDTH'(load);
    dout_d    = load ? mem[rd_ptr_q] : dout_q;
    dval_d    = load || (dval_q && !rd_acc);
    empty_d   = !dval_d;
`else
    rd_ptr_d  = rd_ptr_q + ADDRESS_WIDTH'(rd_acc);
    dout_d    = rd_acc ? mem[rd_ptr_q] : dout_q;
    dval_d    = rd_acc;
    empty_d   = (cnt_d == '0);
`endif
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.din;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= (AFULL_C == '0);
      aempty_q  <= 1'b1;
      dout_q    <= '0;
      dval_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
`ifdef FIFO_SYNC_FWFT_EN
      ram_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      dout_q    <= dout_d;
      dval_q    <= dval_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
`ifdef FIFO_SYNC_FWFT_EN
      ram_cnt_q <= ram_cnt_d;
`endif
    end
  end

  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = aempty_q;
  assign bus.cnt          = cnt_q;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dval_q;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;
endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: queue reference model plus read scoreboard.
// Depth 16, almost-full 12, almost-empty 2.
module tb_fifo_sync;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  typedef struct {
    logic [DW-1:0] d;
    int            cyc;
  } ent_t;

  logic clk;
  logic rst;
  fifo_sync_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  fifo_sync #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH),
    .AFULL_LVL(AF), .AEMPTY_LVL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t          mq [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] hold_m;
  bit            ovf_m, udf_m, armed;
  int            cyc;
  int            n_cmp, n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Head word is visible once it has been stored for a full cycle
  // in FWFT mode; in standard mode only occupancy matters.
  function automatic bit m_empty();
    if (mq.size() == 0) return 1'b1;
`ifdef FIFO_SYNC_FWFT_EN
    if (mq[0].cyc == cyc) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    bit fl, em;
    ent_t e;
    bus.wr = w;
    bus.din = d;
    bus.rd = r;
    bus.err_clr = c;
    fl = (mq.size() == DEPTH);
    em = m_empty();
    @(posedge clk);
    cyc++;
    ovf_m = (w && fl) || (ovf_m && !c);
    udf_m = (r && em) || (udf_m && !c);
    if (r && !em) begin
      e = mq.pop_front();
      hold_m = e.d;
`ifndef FIFO_SYNC_FWFT_EN
      exp_q.push_back(e.d);
`endif
    end
    if (w && !fl) mq.push_back('{d: d, cyc: cyc});
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.err_clr = 1'b0;
    bus.din = '0;
    @(posedge clk);
    cyc++;
    mq.delete();
    exp_q.delete();
    hold_m = '0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
    armed = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Monitor: flags every cycle, read data against the scoreboard.
  always @(negedge clk) begin
    if (armed) begin
      chk("cnt", 32'(bus.cnt), mq.size());
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= AF));
      chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= AE));
      chk("empty", 32'(bus.empty), 32'(m_empty()));
      chk("ovf", 32'(bus.ovf), 32'(ovf_m));
      chk("udf", 32'(bus.udf), 32'(udf_m));
`ifdef FIFO_SYNC_FWFT_EN
      chk("dout_valid", 32'(bus.dout_valid), 32'(!m_empty()));
      if (!m_empty()) chk("dout_head", 32'(bus.dout), 32'(mq[0].d));
`else
      chk("dout_valid", 32'(bus.dout_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        if (bus.dout_valid) chk("dout", 32'(bus.dout), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        chk("dout_hold", 32'(bus.dout), 32'(hold_m));
      end
`endif
    end
  end

  initial begin
    rst = 1'b1;
    armed = 1'b0;
    cyc = 0;
    n_cmp = 0;
    n_bad = 0;
    hold_m = '0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.err_clr = 1'b0;
    bus.din = '0;

    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_cnt", 32'(bus.cnt), 0);
    chk("rst_dout", 32'(bus.dout), 0);

    for (int i = 1; i <= 16; i++) begin
      step(1, DW'(i), 0, 0);
      if (i == 12) chk("afull_at12", 32'(bus.almost_full), 1);
    end
    chk("full16", 32'(bus.full), 1);
    chk("cnt16", 32'(bus.cnt), 16);
    step(1, 8'hAA, 0, 0);
    chk("ovf_set", 32'(bus.ovf), 1);
    chk("cnt_after_ovf", 32'(bus.cnt), 16);
    for (int i = 1; i <= 16; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("drained_empty", 32'(bus.empty), 1);

    step(0, 0, 1, 0);
    chk("udf_set", 32'(bus.udf), 1);
    chk("udf_cnt0", 32'(bus.cnt), 0);
    step(0, 0, 0, 1);
    chk("udf_clr", 32'(bus.udf), 0);
    chk("ovf_clr", 32'(bus.ovf), 0);

    for (int i = 0; i < 8; i++) step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(1, DW'($urandom), 1, 0);
    chk("cnt_steady8", 32'(bus.cnt), 8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 5; i++) step(1, DW'(8'h90 + i), 0, 0);
    do_reset();
    chk("cnt_after_rst", 32'(bus.cnt), 0);
    step(1, 8'h55, 0, 0);
    step(0, 0, 0, 0);
`ifdef FIFO_SYNC_FWFT_EN
    chk("no_stale", 32'(bus.dout), 32'h55);
`endif
    step(0, 0, 1, 0);
`ifndef FIFO_SYNC_FWFT_EN
    chk("no_stale", 32'(bus.dout), 32'h55);
`endif
    step(0, 0, 0, 0);

`ifdef FIFO_SYNC_FWFT_EN
    step(1, 8'h3C, 0, 0);
    chk("fwft_e_empty", 32'(bus.empty), 1);
    step(0, 0, 0, 0);
    chk("fwft_e1_empty", 32'(bus.empty), 0);
    chk("fwft_e1_dout", 32'(bus.dout), 32'h3C);
    step(0, 0, 1, 0);
    chk("fwft_pop_empty", 32'(bus.empty), 1);
`endif

    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 80; i++) begin
        int wp;
        wp = (ph % 2 == 0) ? 75 : 25;
        if ($urandom_range(0, 199) == 0) do_reset();
        else step($urandom_range(0, 99) < wp, DW'($urandom),
                  $urandom_range(0, 99) < (100 - wp),
                  $urandom_range(0, 15) == 0);
      end
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, parametrised FIFO: the synchronous successor to the dual-clock FIFO. It is used where producer and consumer share one clock, such as channel sample buffering in the imitator datapath. Compared with the dual-clock FIFO it adds an exact occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A first-word-fall-through read mode can be compiled in.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDRESS_WIDTH, 12, pointer width; minimum 2.
- FIFO_DEPTH, 1<<ADDRESS_WIDTH, capacity in words; always a power of two.
- AFULL_LVL, FIFO_DEPTH-4, almost_full asserts when cnt >= AFULL_LVL.
- AEMPTY_LVL, 4, almost_empty asserts when cnt <= AEMPTY_LVL.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  write data.
- wr  in  1  write request.
- full  out  1  cnt == FIFO_DEPTH.
- almost_full  out  1  cnt >= AFULL_LVL.
- dout  out  DATA_WIDTH  read data (registered).
- rd  in  1  read request.
- dout_valid  out  1  dout holds a newly read word (standard mode).
- empty  out  1  no readable word.
- almost_empty  out  1  cnt <= AEMPTY_LVL.
- cnt  out  ADDRESS_WIDTH+1  exact occupancy, 0..FIFO_DEPTH.
- err_clr  in  1  clears ovf and udf.
- ovf  out  1  sticky: a write was attempted while full.
- udf  out  1  sticky: a read was attempted while empty.

## Operation
- Storage:
  - Dual-port RAM, FIFO_DEPTH x DATA_WIDTH.
  - Binary write and read pointers, ADDRESS_WIDTH bits each; they wrap modulo FIFO_DEPTH.
- Accept rules:
  - A write is accepted iff wr && !full.
  - A read is accepted iff rd && !empty.
  - full and empty are evaluated from registered state only. A write while full is rejected even if a read is accepted in the same cycle.
- cnt arithmetic:
  - +1 on an accepted write alone.
  - -1 on an accepted read alone.
  - Unchanged when both are accepted.
  - cnt is a counter, never a pointer difference, so wrap-around cannot corrupt it.
- Flags:
  - full, empty, almost_full and almost_empty are registered and consistent with cnt in the same cycle.
- Errors:
  - ovf sets on wr && full; udf sets on rd && empty.
  - Both hold until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the set wins.
  - Rejected requests never change pointers, cnt or memory.
- Reset:
  - Pointers and cnt go to 0; dout goes to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0 (for AFULL_LVL>0).
  - dout_valid=0, ovf=0, udf=0.
  - A reset mid-operation discards all contents. Memory contents are not cleared.

## Timing
- A write accepted at edge E updates cnt and flags after E. The word is readable from the cycle after E.
- Standard mode:
  - A read accepted at edge E puts the word on dout after E, with dout_valid=1 for that one cycle.
  - dout holds its value between reads.
- Full-to-not-full and empty-to-not-empty transitions take effect in the cycle after the causing edge. No combinational path exists from wr/rd to full/empty.
- Back-to-back reads and writes every cycle are sustained at one word per clock.

## Configuration
- Macro FIFO_SYNC_FWFT_EN:
  - Defined: first-word-fall-through mode.
    - dout always shows the head word whenever empty=0, and rd pops it.
    - Internally, an output register is prefetched from RAM.
    - A write into an empty FIFO at edge E loads the output register at E+1; empty falls after E+1.
    - cnt includes the word held in the output register; total capacity stays FIFO_DEPTH.
    - dout_valid is tied to !empty.
  - Undefined: standard registered-read behaviour as described under Operation and Timing.

## Test plan
Bench uses DATA_WIDTH=8, ADDRESS_WIDTH=4 (depth 16), AFULL_LVL=12, AEMPTY_LVL=2.
- Reset then idle -> empty=1, almost_empty=1, full=0, cnt=0, dout=0x00, ovf=0, udf=0.
- Write 0x01..0x10 (16 words), then one more write of 0xAA -> full=1 and cnt=16 after the 16th write; almost_full=1 from cnt=12; the 17th write sets ovf=1 and memory is unchanged. Then read 16 -> dout sequence 0x01..0x10 with dout_valid per read; empty=1 at the end.
- Read on an empty FIFO -> udf=1, cnt stays 0. Pulse err_clr -> udf=0 next cycle.
- Preload 8 words, then simultaneous wr/rd for 40 cycles across pointer wrap -> cnt constant at 8 and output order preserved.
- Write 5 words, assert rst mid-stream, then write 0x55 and read -> cnt=0 after reset; the read returns 0x55 (no stale data).
- With FIFO_SYNC_FWFT_EN: write 0x3C into an empty FIFO at edge E -> empty=0 and dout=0x3C after E+1 with no rd; rd pops it, and empty=1 next cycle.
